// File: rtl/pll_freq_monitor.sv
// Measures a divided-down PLL output against the reference clock over fixed gate windows
// and qualifies it once LOCK_WINDOWS consecutive windows land within tolerance.
`timescale 1ns/1ps
module pll_freq_monitor #(
   parameter int GATE_CYCLES  = 50000,
   parameter int CNT_W        = 16,
   parameter int EXP_COUNT    = 25000,
   parameter int TOL          = 25,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pll_locked,
   input  logic             meas_tog,
   input  logic             err_clr,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             freq_ok,
   output logic             err_sticky
);

   localparam int GATE_W = $clog2(GATE_CYCLES + 1);
   localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W:0]    EXP_V     = (CNT_W+1)'(EXP_COUNT);
   localparam logic [CNT_W:0]    TOL_V     = (CNT_W+1)'(TOL);
   localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_WINDOWS);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

   state_t            state;
   state_t            next_state;
   logic              tog_s1, tog_s2, tog_s3;
   logic              lock_s1, lock_s2;
   logic              tog_edge;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_next;
   logic [CNT_W:0]    cnt_ext;
   logic [CNT_W:0]    diff;
   logic              in_tol;
   logic              report_fire;
   logic              err_set;

   // Both asynchronous inputs get two flops; the toggle gets a third so either edge is seen.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         tog_s1  <= 1'b0;
         tog_s2  <= 1'b0;
         tog_s3  <= 1'b0;
         lock_s1 <= 1'b0;
         lock_s2 <= 1'b0;
      end else begin
         tog_s1  <= meas_tog;
         tog_s2  <= tog_s1;
         tog_s3  <= tog_s2;
         lock_s1 <= pll_locked;
         lock_s2 <= lock_s1;
      end
   end

   assign tog_edge = tog_s2 ^ tog_s3;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    next_state = ARM;
            ARM:     if (lock_s2) next_state = MEASURE;
            MEASURE: begin
               if (!lock_s2) begin
                  next_state = ARM;
               end else if (gate_cnt == GATE_LAST) begin
                  next_state = REPORT;
               end
            end
            REPORT:  next_state = lock_s2 ? MEASURE : ARM;
            default: next_state = IDLE;
         endcase
      end
   end

   // A window only counts if the FSM is carrying on into the next one; a REPORT cut short
   // by lock loss or disable is discarded like any other partial window.
   always_comb begin
      report_fire = (state == REPORT) && (next_state == MEASURE);
      cnt_ext     = {1'b0, edge_cnt};
      diff        = (cnt_ext >= EXP_V) ? (cnt_ext - EXP_V) : (EXP_V - cnt_ext);
      in_tol      = (diff <= TOL_V);
      good_next   = good_cnt;
      if (next_state == IDLE || next_state == ARM) begin
         good_next = '0;
      end else if (report_fire) begin
         if (!in_tol) begin
            good_next = '0;
         end else if (good_cnt != GOOD_MAX) begin
            good_next = good_cnt + 1'b1;
         end
      end
      err_set = freq_ok && (good_next != GOOD_MAX) && enable;
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         gate_cnt <= '0;
      end else if (state == MEASURE && gate_cnt != GATE_LAST) begin
         gate_cnt <= gate_cnt + 1'b1;
      end else begin
         gate_cnt <= '0;
      end
   end

   // Reloading with the REPORT-cycle edge keeps back-to-back windows gap-free.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         edge_cnt <= '0;
      end else begin
         case (state)
            MEASURE: if (tog_edge && edge_cnt != CNT_MAX) edge_cnt <= edge_cnt + 1'b1;
            REPORT:  edge_cnt <= CNT_W'(tog_edge);
            default: edge_cnt <= '0;
         endcase
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         count_out   <= '0;
         count_valid <= 1'b0;
         good_cnt    <= '0;
         err_sticky  <= 1'b0;
      end else begin
         count_valid <= report_fire;
         if (report_fire) count_out <= edge_cnt;
         good_cnt <= good_next;
         if (err_set) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

   assign freq_ok = (good_cnt == GOOD_MAX);

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Randomized bench for pll_freq_monitor: counts expected edges from the toggle timestamps it
// generates and checks every cycle, plus directed checks for qualification, errors and lock loss.
`timescale 1ns/1ps
module tb_pll_freq_monitor;

   localparam int GATE = 1000;
   localparam int EXP  = 500;
   localparam int TOLR = 2;
   localparam int LW   = 4;

   logic        refclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        pll_locked = 1'b0;
   logic        meas_tog = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] count_out;
   logic        count_valid, freq_ok, err_sticky;
   logic [7:0]  sat_count;
   logic        sat_valid, sat_ok, sat_err;

   pll_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(16), .EXP_COUNT(EXP), .TOL(TOLR),
                      .LOCK_WINDOWS(LW)) dut (
      .refclk(refclk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
      .meas_tog(meas_tog), .err_clr(err_clr), .count_out(count_out),
      .count_valid(count_valid), .freq_ok(freq_ok), .err_sticky(err_sticky));

   pll_freq_monitor #(.GATE_CYCLES(GATE), .CNT_W(8), .EXP_COUNT(EXP), .TOL(TOLR),
                      .LOCK_WINDOWS(LW)) sat_dut (
      .refclk(refclk), .rst_n(rst_n), .enable(enable), .pll_locked(pll_locked),
      .meas_tog(meas_tog), .err_clr(err_clr), .count_out(sat_count),
      .count_valid(sat_valid), .freq_ok(sat_ok), .err_sticky(sat_err));

   initial forever #10 refclk = ~refclk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int hist[100000];
   int tog_total = 0;
   int half_ps = 40000;
   int jit_ps = 300;

   int next_valid = -1;
   bit first_win = 1'b0;
   int good_m = 0;
   bit err_m = 1'b0;
   bit clr_prev = 1'b0;
   int cnt_m = 0;
   int sat_m = 0;
   int lock_fall = -10;
   int en_fall = -10;
   int lock_rise = 0;
   int en_rise = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drives the inputs and notes when enable/lock change, which fixes the next window's timing.
   task automatic applyStimulus(input logic en, input logic lk, input logic clr);
      if (lk && !pll_locked) lock_rise = cyc;
      if (!lk && pll_locked) lock_fall = cyc;
      if (en && !enable) en_rise = cyc;
      if (!en && enable) en_fall = cyc;
      if (en && lk && (!enable || !pll_locked)) begin
         next_valid = (en_rise + GATE + 3 > lock_rise + GATE + 4) ? en_rise + GATE + 3
                                                                   : lock_rise + GATE + 4;
         first_win = 1'b1;
      end
      enable = en;
      pll_locked = lk;
      err_clr = clr;
   endtask

   task automatic waitValid(input int bound, input string tag);
      int k = 0;
      do begin
         @(negedge refclk);
         k++;
      end while (count_valid !== 1'b1 && k < bound);
      checkOutput(tag, count_valid, 1);
   endtask

   // Measured clock: toggles every half_ps with jitter, never exactly on a refclk edge.
   initial begin
      longint t_ps;
      int d;
      t_ps = 0;
      d = 3000 + $urandom_range(0, 15000);
      forever begin
         if ((t_ps + d) % 1000 == 0) d++;
         #(d * 0.001);
         t_ps += d;
         meas_tog = ~meas_tog;
         tog_total++;
         d = half_ps + int'($urandom_range(0, 2 * jit_ps)) - jit_ps;
      end
   end

   initial forever begin
      @(posedge refclk);
      cyc = cyc + 1;
      if (cyc < 100000) hist[cyc] = tog_total;
   end

   // Reference model: a window reported in cycle n covers the toggles that reached the
   // synchronizer output over the GATE (or GATE+1 when back-to-back) cycles before it.
   initial forever begin
      int n, edges;
      bit fo_prev, set_now, en_drop, valid_hit;
      @(negedge refclk);
      valid_hit = 1'b0;
      set_now = 1'b0;
      en_drop = 1'b0;
      fo_prev = (good_m == LW);
      if (rst_n) begin
         n = cyc;
         if (n == lock_fall + 3) begin
            good_m = 0;
            if (next_valid >= n) next_valid = -1;
         end
         if (n == en_fall + 1) begin
            good_m = 0;
            en_drop = 1'b1;
            if (next_valid >= n) next_valid = -1;
         end
         if (n == next_valid) begin
            edges = hist[n - 3] - hist[n - GATE - (first_win ? 3 : 4)];
            valid_hit = 1'b1;
            cnt_m = (edges > 65535) ? 65535 : edges;
            sat_m = (edges > 255) ? 255 : edges;
            if (cnt_m - EXP <= TOLR && EXP - cnt_m <= TOLR) good_m = (good_m < LW) ? good_m + 1 : LW;
            else good_m = 0;
            next_valid = n + GATE + 1;
            first_win = 1'b0;
         end
         if (fo_prev && good_m != LW && !en_drop) set_now = 1'b1;
         if (set_now) err_m = 1'b1;
         else if (clr_prev) err_m = 1'b0;
         clr_prev = err_clr;
      end
      checkOutput("count_valid", count_valid, valid_hit);
      checkOutput("count_out", count_out, cnt_m);
      checkOutput("freq_ok", freq_ok, (good_m == LW));
      checkOutput("err_sticky", err_sticky, err_m);
      checkOutput("sat_count_valid", sat_valid, valid_hit);
      checkOutput("sat_count_out", sat_count, sat_m);
      checkOutput("sat_freq_ok", sat_ok, 0);
      checkOutput("sat_err_sticky", sat_err, 0);
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int j, k, nv;
      repeat (4) @(posedge refclk);
      @(negedge refclk);
      checkOutput("reset_count_out", count_out, 0);
      checkOutput("reset_count_valid", count_valid, 0);
      checkOutput("reset_freq_ok", freq_ok, 0);
      checkOutput("reset_err_sticky", err_sticky, 0);
      @(posedge refclk); #1;
      rst_n = 1'b1;
      applyStimulus(1, 1, 0);
      j = cyc;

      waitValid(GATE + 20, "first_valid_seen");
      checkOutput("first_valid_latency", (cyc - j >= GATE + 3 && cyc - j <= GATE + 5), 1);
      checkOutput("first_count_range", (count_out >= 499 && count_out <= 501), 1);
      checkOutput("first_freq_ok", freq_ok, 0);
      repeat (3) waitValid(GATE + 20, "qual_valid_seen");
      checkOutput("qualified_freq_ok", freq_ok, 1);
      checkOutput("qualified_err", err_sticky, 0);

      half_ps = 48000 + $urandom_range(0, 4000);
      waitValid(GATE + 20, "slow_valid_seen");
      checkOutput("slow_count_range", (count_out >= 370 && count_out <= 430), 1);
      checkOutput("slow_freq_ok", freq_ok, 0);
      checkOutput("slow_err_set", err_sticky, 1);

      half_ps = 40000;
      repeat (4) waitValid(GATE + 20, "restore_valid_seen");
      checkOutput("restored_freq_ok", freq_ok, 1);
      checkOutput("restored_err_held", err_sticky, 1);
      @(posedge refclk); #1; applyStimulus(1, 1, 1);
      @(posedge refclk); #1; applyStimulus(1, 1, 0);
      @(negedge refclk);
      checkOutput("err_cleared", err_sticky, 0);

      for (int i = 0; i < 4; i++) begin
         half_ps = 39760 + $urandom_range(0, 480);
         repeat (2) waitValid(GATE + 20, "edge_tol_valid_seen");
      end
      half_ps = 40000;

      k = 0;
      do begin
         waitValid(GATE + 20, "requal_valid_seen");
         k++;
      end while (freq_ok !== 1'b1 && k < 10);
      checkOutput("requalified", freq_ok, 1);
      @(posedge refclk); #1; applyStimulus(1, 1, 1);
      @(posedge refclk); #1; applyStimulus(1, 1, 0);
      repeat (298) @(posedge refclk);
      #1; applyStimulus(1, 0, 0);
      @(posedge refclk); #1;
      @(posedge refclk); #1; applyStimulus(1, 0, 1);
      @(negedge refclk);
      checkOutput("ok_before_lock_sync", freq_ok, 1);
      @(posedge refclk); #1; applyStimulus(1, 0, 0);
      @(negedge refclk);
      checkOutput("lock_loss_freq_ok", freq_ok, 0);
      checkOutput("lock_loss_set_wins", err_sticky, 1);
      @(posedge refclk); #1; applyStimulus(1, 0, 1);
      @(posedge refclk); #1; applyStimulus(1, 0, 0);
      @(negedge refclk);
      checkOutput("late_clr", err_sticky, 0);
      nv = 0;
      repeat (GATE + 100) begin
         @(negedge refclk);
         if (count_valid === 1'b1) nv++;
      end
      checkOutput("no_valid_without_lock", nv, 0);
      @(posedge refclk); #1; applyStimulus(1, 1, 0);
      j = cyc;
      waitValid(GATE + 20, "relock_valid_seen");
      checkOutput("relock_latency", cyc - j, GATE + 4);
      checkOutput("relock_count_range", (count_out >= 499 && count_out <= 501), 1);

      k = 0;
      do begin
         waitValid(GATE + 20, "pre_disable_valid_seen");
         k++;
      end while (freq_ok !== 1'b1 && k < 6);
      checkOutput("pre_disable_freq_ok", freq_ok, 1);
      repeat (100 + $urandom_range(0, 400)) @(posedge refclk);
      #1; applyStimulus(0, 1, 0);
      @(posedge refclk);
      @(negedge refclk);
      checkOutput("disable_freq_ok", freq_ok, 0);
      checkOutput("disable_no_err", err_sticky, 0);
      repeat (20) @(posedge refclk);
      #1; applyStimulus(1, 1, 0);
      j = cyc;
      waitValid(GATE + 20, "reenable_valid_seen");
      checkOutput("reenable_latency", cyc - j, GATE + 3);

      @(posedge refclk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
